// File: rtl/instrumented_adder_meas.sv
// ---------------------------------------------------------------------------
// instrumented_adder_meas
//
// Measurement sequencer for an instrumented adder under test (AUT).
// It loads the operands and drives them into the AUT. It can close a ring
// oscillator through selected bits of operand A. It counts rising edges of
// the AUT chain output over a programmed window, then captures the AUT sum.
//
// Sequence: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE
//   LOAD  : latch operands, ring mask and window length; clear the counter.
//   RUN   : ring feedback enabled for exactly stop_time cycles.
//   DRAIN : ring broken; edges still in the sampling pipeline are counted.
//   DONE  : one-cycle done pulse; results published.
//
// Compile-time option
//   INSTR_ADDER_SYNC_EN : chain_out goes through a 2-flop synchroniser before
//                         edge detection. DRAIN becomes 3 cycles and the
//                         start->done latency becomes stop_time+5.
//                         Undefined: one sampling flop, DRAIN 2 cycles,
//                         latency stop_time+4.
//
// Parameters
//   WIDTH : adder operand/sum width
//   CNT_W : width of the window timer, stop_time and ring_count
//
// Ports
//   wb_clk_i   in   1      clock
//   wb_rst_ni  in   1      synchronous reset, active-low
//   active     in   1      design select; low aborts to IDLE synchronously
//   start      in   1      level request, sampled only in IDLE
//   stop_time  in   CNT_W  RUN window length in cycles
//   cfg_a      in   WIDTH  operand A value
//   cfg_b      in   WIDTH  operand B value
//   cfg_ring   in   WIDTH  per bit: 1 = A bit driven by ring feedback
//   adder_a    out  WIDTH  operand A to AUT (ring bits combinational)
//   adder_b    out  WIDTH  operand B to AUT
//   adder_s    in   WIDTH  AUT sum
//   chain_out  in   1      AUT ring/carry output, asynchronous
//   busy       out  1      high in LOAD/RUN/DRAIN/DONE
//   done       out  1      one-cycle completion pulse
//   ring_count out  CNT_W  chain_out rising edges in the last window
//   sum_out    out  WIDTH  adder_s captured at completion
//   count_ovf  out  1      ring_count saturated in the last window
// ---------------------------------------------------------------------------
module instrumented_adder_meas #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             active,
    input  logic             start,
    input  logic [CNT_W-1:0] stop_time,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    input  logic [WIDTH-1:0] cfg_ring,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_s,
    input  logic             chain_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ring_count,
    output logic [WIDTH-1:0] sum_out,
    output logic             count_ovf
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Index of the last DRAIN cycle. DRAIN must outlast the sampling
    // pipeline so that every edge seen during RUN reaches the counter.
`ifdef INSTR_ADDER_SYNC_EN
    localparam logic [1:0] DRAIN_LAST = 2'd2;
`else
    localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

    state_t           state;
    logic             ring_en;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ring_q;
    logic [CNT_W-1:0] timer;
    logic [1:0]       drain_cnt;

    // Working edge counter for the window in progress. It is published to
    // ring_count/count_ovf only on completion. An aborted window therefore
    // never disturbs the last reported result.
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    // chain_out sampling: chain_p1 is the current sample and chain_p2 the
    // previous one.
    logic chain_p1;
    logic chain_p2;
    logic rise;

    // Saturating increment. Returns {overflow, count}. The overflow flag is
    // sticky: it is set on any increment attempted at all-ones.
    function automatic logic [CNT_W:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             ovf,
        input logic             inc
    );
        logic [CNT_W:0] res;
        res = {ovf, cnt};
        if (inc) begin
            if (&cnt) begin
                res[CNT_W] = 1'b1;
            end else begin
                res[CNT_W-1:0] = cnt + CNT_W'(1);
            end
        end
        return res;
    endfunction

    // ---- AUT operand drive ----
    // The ring path is intentionally combinational from chain_out. Clearing
    // ring_en breaks the loop, which leaves plain a_q bits.
    assign adder_a = (a_q & ~ring_q) | (ring_q & {WIDTH{ring_en & ~chain_out}});
    assign adder_b = b_q;

    // ---- chain_out sampling ----
`ifdef INSTR_ADDER_SYNC_EN
    logic chain_p0;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            chain_p0 <= 1'b0;
            chain_p1 <= 1'b0;
            chain_p2 <= 1'b0;
        end else begin
            chain_p0 <= chain_out;
            chain_p1 <= chain_p0;
            chain_p2 <= chain_p1;
        end
    end
`else
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            chain_p1 <= 1'b0;
            chain_p2 <= 1'b0;
        end else begin
            chain_p1 <= chain_out;
            chain_p2 <= chain_p1;
        end
    end
`endif

    assign rise = chain_p1 & ~chain_p2;

    // ---- edge count next value ----
    // Edges are counted only in RUN and DRAIN.
    always_comb begin
        logic [CNT_W:0] inc_res;
        inc_res = sat_inc(cnt_q, ovf_q, rise & ((state == RUN) | (state == DRAIN)));
        cnt_nxt = inc_res[CNT_W-1:0];
        ovf_nxt = inc_res[CNT_W];
    end

    // ---- sequencer ----
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            ring_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ring_q     <= '0;
            timer      <= '0;
            drain_cnt  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ring_count <= '0;
            count_ovf  <= 1'b0;
            sum_out    <= '0;
        end else if (!active) begin
            // Deselected: drop back to IDLE. Published results are held.
            state     <= IDLE;
            ring_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end

                LOAD: begin
                    a_q       <= cfg_a;
                    b_q       <= cfg_b;
                    ring_q    <= cfg_ring;
                    timer     <= stop_time;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    drain_cnt <= '0;
                    // A zero-length window skips RUN, so the ring never closes.
                    if (stop_time == '0) begin
                        state <= DRAIN;
                    end else begin
                        state   <= RUN;
                        ring_en <= 1'b1;
                    end
                end

                RUN: begin
                    timer <= timer - CNT_W'(1);
                    cnt_q <= cnt_nxt;
                    ovf_q <= ovf_nxt;
                    if (timer == CNT_W'(1)) begin
                        state   <= DRAIN;
                        ring_en <= 1'b0;
                    end
                end

                DRAIN: begin
                    cnt_q     <= cnt_nxt;
                    ovf_q     <= ovf_nxt;
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        // Publish on entry to DONE so the results line up with
                        // the done pulse. This includes any edge counted on
                        // this last DRAIN cycle.
                        state      <= DONE;
                        done       <= 1'b1;
                        sum_out    <= adder_s;
                        ring_count <= cnt_nxt;
                        count_ovf  <= ovf_nxt;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ring_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instrumented_adder_meas.sv
// ---------------------------------------------------------------------------
// Testbench for instrumented_adder_meas.
// The main instance uses default widths. The bench models the AUT as a
// plain adder.
// A second instance with a 1-bit counter exercises saturation. The timer
// shares the counter width, and an edge needs two samples. So a window can
// only produce more edges than the counter can hold when the counter is
// very narrow.
// The reference count is taken from a history of chain_out values recorded
// at every clock edge. The counted window is stop_time+2 sample intervals
// that end two edges after RUN finishes. With the synchroniser option the
// window starts one interval earlier.
// ---------------------------------------------------------------------------
module tb_instrumented_adder_meas;

`ifdef INSTR_ADDER_SYNC_EN
    localparam int LAT = 5;
    localparam int JLO = 0;
`else
    localparam int LAT = 4;
    localparam int JLO = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, active, start;
    logic [31:0] stop_time, cfg_a, cfg_b, cfg_ring;
    logic [31:0] adder_a, adder_b, adder_s, sum_out, ring_count;
    logic        chain_out, busy, done, count_ovf;

    logic        start2;
    logic [0:0]  stop2;
    logic [31:0] a2, b2, s2, sum2;
    logic        chain2, busy2, done2, ovf2;
    logic [0:0]  cnt2;

    assign adder_s = adder_a + adder_b;
    assign s2      = a2 + b2;

    instrumented_adder_meas #(.WIDTH(32), .CNT_W(32)) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .active(active), .start(start),
        .stop_time(stop_time), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ring(cfg_ring),
        .adder_a(adder_a), .adder_b(adder_b), .adder_s(adder_s),
        .chain_out(chain_out), .busy(busy), .done(done),
        .ring_count(ring_count), .sum_out(sum_out), .count_ovf(count_ovf)
    );

    instrumented_adder_meas #(.WIDTH(32), .CNT_W(1)) u_sat (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .active(active), .start(start2),
        .stop_time(stop2), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ring(cfg_ring),
        .adder_a(a2), .adder_b(b2), .adder_s(s2),
        .chain_out(chain2), .busy(busy2), .done(done2),
        .ring_count(cnt2), .sum_out(sum2), .count_ovf(ovf2)
    );

    // chain_out drivers: they update on the falling edge.
    // cmode 0 = hold clevel, 1 = toggle every cper cycles, 2 = random.
    int   cmode = 0;
    int   cper  = 1;
    int   tick  = 0;
    logic clevel = 1'b0;
    logic c2tog  = 1'b0;
    logic c2val  = 1'b0;

    initial begin
        chain_out = 1'b0;
        chain2    = 1'b0;
    end

    always @(negedge clk) begin
        tick <= tick + 1;
        case (cmode)
            0:       chain_out <= clevel;
            1:       if (tick % cper == 0) chain_out <= ~chain_out;
            default: chain_out <= 1'($urandom);
        endcase
        chain2 <= c2tog ? ~chain2 : c2val;
    end

    // History of chain inputs at each rising edge.
    int   edge_n = 0;
    logic hist  [8192];
    logic hist2 [8192];

    always @(posedge clk) begin
        hist[edge_n & 8191]  <= chain_out;
        hist2[edge_n & 8191] <= chain2;
        edge_n               <= edge_n + 1;
    end

    int n_asrt = 0;
    int n_fail = 0;

    logic [31:0] last_cnt;
    logic [31:0] last_sum;
    logic        last_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_rises(input bit sat, input int s0, input int st);
        int   c;
        logic p, q;
        c = 0;
        for (int j = JLO; j <= st + 2; j++) begin
            p = sat ? hist2[(s0 + j - 1) & 8191] : hist[(s0 + j - 1) & 8191];
            q = sat ? hist2[(s0 + j) & 8191]     : hist[(s0 + j) & 8191];
            if (!p && q) c++;
        end
        return c;
    endfunction

    // One complete measurement on the main instance. It is called at
    // negedge+2. hold keeps start high throughout. pulse_at raises start
    // for one cycle that many edges after the trigger edge.
    task automatic run_check(input string tag, input int st, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ring,
                             input bit hold, input int pulse_at);
        int          s0, n, lat, exp_cnt;
        logic [31:0] exp_a;
        cfg_a     = a;
        cfg_b     = b;
        cfg_ring  = ring;
        stop_time = st;
        start     = 1'b1;
        s0        = edge_n;
        lat       = -1;
        for (int k = 0; k < st + 40; k++) begin
            @(negedge clk); #2;
            n = edge_n - s0;
            if (!hold) start = (pulse_at > 0 && n == pulse_at);
            if (n == 1) check({tag, "_busy_load"}, 64'(busy), 64'd1);
            if (n == 3 && st >= 2) begin
                exp_a = (a & ~ring) | (ring & ~{32{chain_out}});
                check({tag, "_adder_a_run"}, 64'(adder_a), 64'(exp_a));
                check({tag, "_adder_b"}, 64'(adder_b), 64'(b));
            end
            if (n == 2 && st == 0)
                check({tag, "_adder_a_noring"}, 64'(adder_a), 64'(a & ~ring));
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(st + LAT));
        exp_cnt = count_rises(1'b0, s0, st);
        check({tag, "_ring_count"}, 64'(ring_count), 64'(exp_cnt));
        check({tag, "_count_ovf"}, 64'(count_ovf), 64'd0);
        check({tag, "_sum_out"}, 64'(sum_out), 64'((a & ~ring) + b));
        last_cnt = 32'(exp_cnt);
        last_sum = (a & ~ring) + b;
        last_ovf = 1'b0;
        @(negedge clk); #2;
        check({tag, "_done_1cycle"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int s0, lat, m;
        bit seen;

        rst_n = 1'b0; active = 1'b1; start = 1'b0; start2 = 1'b0;
        stop_time = '0; stop2 = '0;
        cfg_a = 32'hDEAD_BEEF; cfg_b = 32'h1234_5678; cfg_ring = 32'hFFFF_FFFF;

        // Reset: everything cleared.
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ring_count", 64'(ring_count), 64'd0);
        check("rst_sum_out", 64'(sum_out), 64'd0);
        check("rst_count_ovf", 64'(count_ovf), 64'd0);
        check("rst_adder_a", 64'(adder_a), 64'd0);
        check("rst_adder_b", 64'(adder_b), 64'd0);
        check("rst_busy_sat", 64'(busy2), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #2;

        // Window: chain toggling every cycle, ring on bit 0, 10-cycle window.
        cmode = 1; cper = 1;
        run_check("window", 10, 32'h1234_5678, 32'h0000_0F00, 32'h1, 1'b0, 0);
        check("window_range", 64'(ring_count >= 5 && ring_count <= 7), 64'd1);

        // Sum only, zero window, ring never closes.
        cmode = 0; clevel = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        run_check("sum", 0, 32'h0000_FFFF, 32'h1, 32'h0, 1'b0, 0);
        check("sum_value", 64'(sum_out), 64'h0001_0000);
        check("sum_count_zero", 64'(ring_count), 64'd0);
        run_check("zero_win_ring", 0, $urandom, $urandom, 32'hF0F0_F0F0, 1'b0, 0);

        // Randomised windows, operands and ring masks.
        cmode = 2;
        for (int i = 0; i < 6; i++)
            run_check("rand", int'($urandom_range(1, 25)), $urandom, $urandom, $urandom, 1'b0, 0);

        // Re-trigger with start held, then a second run with a start pulse in RUN.
        run_check("retrig1", 5, $urandom, $urandom, $urandom, 1'b1, 0);
        run_check("retrig2", 7, $urandom, $urandom, $urandom, 1'b0, 4);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk); #2;
            if (busy || done) seen = 1'b1;
        end
        check("pulse_ignored", 64'(seen), 64'd0);

        // Abort at RUN cycle 3, then retry.
        cfg_a = $urandom; cfg_b = $urandom; cfg_ring = $urandom;
        stop_time = 20; start = 1'b1; s0 = edge_n;
        @(negedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("abort_busy_run", 64'(busy), 64'd1);
        active = 1'b0;
        @(negedge clk); #2;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hold_count", 64'(ring_count), 64'(last_cnt));
        check("abort_hold_sum", 64'(sum_out), 64'(last_sum));
        check("abort_hold_ovf", 64'(count_ovf), 64'(last_ovf));
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk); #2;
            if (busy || done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        active = 1'b1;
        run_check("retry", 12, $urandom, $urandom, $urandom, 1'b0, 0);

        // Saturation on the 1-bit instance: chain2 samples 1,0,1,0,1 around
        // the window give two rises into a counter that holds one.
        c2tog = 1'b0; c2val = 1'b1;
        @(negedge clk); #2;
        c2val = 1'b0;
        @(negedge clk); #2;
        stop2 = 1'b1; start2 = 1'b1; c2tog = 1'b1; s0 = edge_n; lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #2;
            start2 = 1'b0;
            if (done2) begin
                lat = edge_n - s0;
                break;
            end
        end
        c2tog = 1'b0;
        m = count_rises(1'b1, s0, 1);
        check("sat_latency", 64'(lat), 64'(1 + LAT));
        check("sat_count", 64'(cnt2), 64'd1);
        check("sat_ovf", 64'(ovf2), 64'd1);
        check("sat_count_model", 64'(cnt2), 64'(m >= 1));
        check("sat_ovf_model", 64'(ovf2), 64'(m > 1));

        // Reset mid-run overrides a concurrent deselect and clears results.
        cmode = 2;
        cfg_a = $urandom | 32'h1; cfg_b = $urandom; cfg_ring = 32'h0;
        stop_time = 20; start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0; active = 1'b0;
        @(negedge clk); #2;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ring_count", 64'(ring_count), 64'd0);
        check("midrst_sum_out", 64'(sum_out), 64'd0);
        check("midrst_count_ovf", 64'(count_ovf), 64'd0);
        check("midrst_adder_a", 64'(adder_a), 64'd0);
        check("midrst_ovf_sat", 64'(ovf2), 64'd0);
        rst_n = 1'b1; active = 1'b1;
        @(negedge clk); #2;
        run_check("after_rst", 9, $urandom, $urandom, $urandom, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
